// File: rtl/clk_div_ratio_ctrl.sv
// clk_div_ratio_ctrl
// Runtime controller for a programmable integer clock divider. Owns the divide
// counter, produces a registered divided output and a per-period tick, and lets
// NREQ requesters change the ratio through req/ack with round-robin arbitration.
// New ratios take effect only at period boundaries (or immediately while the
// divider is stopped), so div_out never shows a runt period.
//
// Optional feature macro: CLKDIV_RATIO1_EN
//   defined   -> ratio 1 is legal (tick == enable, div_out == enable delayed)
//   undefined -> ratio 1 is rejected with err; RESET_RATIO must be >= 2
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | enable low; counter held at 0, div_out forced low
// S_RUN  | enable high, no change pending; arbiter may grant
// S_PEND | enable high, granted ratio latched, waiting for period boundary

module clk_div_ratio_ctrl #(
  parameter int W           = 8,
  parameter int NREQ        = 2,
  parameter int RESET_RATIO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_ratio,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              div_out,
  output logic              tick,
  output logic [W-1:0]      cur_ratio,
  output logic              busy
);

  localparam int             IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0]  RR_INIT = IW'(NREQ - 1);
  localparam logic [W-1:0]   RESET_R = W'(RESET_RATIO);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("clk_div_ratio_ctrl: NREQ must be in 2..8");
  end
`ifdef CLKDIV_RATIO1_EN
  if (RESET_RATIO < 1 || RESET_RATIO > (2**W) - 1) begin : g_bad_reset_ratio
    $error("clk_div_ratio_ctrl: RESET_RATIO must be in 1..2^W-1");
  end
`else
  if (RESET_RATIO < 2 || RESET_RATIO > (2**W) - 1) begin : g_bad_reset_ratio
    $error("clk_div_ratio_ctrl: RESET_RATIO must be in 2..2^W-1");
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    cnt_q;
  logic [W-1:0]    pend_ratio_q;
  logic [IW-1:0]   pend_idx_q;
  logic [IW-1:0]   rr_last_q;

  logic            arb_en;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [W-1:0]    gnt_ratio;
  logic            ratio_ok;
  logic            grant_ok;
  logic            grant_bad;
  logic            boundary;
  logic            apply_now;
  logic            apply_pend;
  logic [W:0]      half_r;

  // Round-robin arbiter: search starts just after the last granted index and
  // is suppressed while a change is pending or an ack is going out.
  always_comb begin
    arb_en  = (state_q != S_PEND) && (ack == '0);
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_last_q) + k) % NREQ);
      if (arb_en && !gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Ratio validation and change-application decode.
  always_comb begin
    gnt_ratio = req_ratio[int'(gnt_idx)*W +: W];
`ifdef CLKDIV_RATIO1_EN
    ratio_ok  = (gnt_ratio != '0);
`else
    ratio_ok  = (gnt_ratio > W'(1));
`endif
    grant_ok   = gnt_any && ratio_ok;
    grant_bad  = gnt_any && !ratio_ok;
    // A stopped divider has no period in flight, so that counts as a boundary.
    boundary   = !enable || tick;
    apply_now  = grant_ok && boundary;
    apply_pend = (state_q == S_PEND) && boundary;
    half_r     = ({1'b0, cur_ratio} + (W+1)'(1)) >> 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: state_d = (grant_ok && !tick) ? S_PEND : S_RUN;
        S_PEND:        state_d = tick ? S_RUN : S_PEND;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  // Combinational outputs.
  always_comb begin
    busy = (state_q == S_PEND);
    tick = enable && (cnt_q == cur_ratio - W'(1));
  end

  // Counter, divided output, ratio register and handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      cur_ratio    <= RESET_R;
      div_out      <= 1'b0;
      ack          <= '0;
      err          <= '0;
      pend_ratio_q <= '0;
      pend_idx_q   <= '0;
      rr_last_q    <= RR_INIT;
    end else begin
      if (!enable || tick) cnt_q <= '0;
      else                 cnt_q <= cnt_q + W'(1);

      div_out <= enable && ({1'b0, cnt_q} < half_r);

      ack <= '0;
      err <= '0;

      if (gnt_any) rr_last_q <= gnt_idx;

      if (grant_bad) begin
        ack[gnt_idx] <= 1'b1;
        err[gnt_idx] <= 1'b1;
      end else if (apply_now) begin
        cur_ratio    <= gnt_ratio;
        ack[gnt_idx] <= 1'b1;
      end else if (grant_ok) begin
        pend_ratio_q <= gnt_ratio;
        pend_idx_q   <= gnt_idx;
      end

      if (apply_pend) begin
        cur_ratio       <= pend_ratio_q;
        ack[pend_idx_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Testbench for clk_div_ratio_ctrl: table-driven start-up vectors, hand-written
// handshake sequences, and a randomized phase checked against a reference model
// that tracks period position, a pending-change deadline and a round-robin
// start index.

module tb_clk_div_ratio_ctrl;

  localparam int W           = 8;
  localparam int NREQ        = 2;
  localparam int RESET_RATIO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_ratio;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic              div_out;
  logic              tick;
  logic [W-1:0]      cur_ratio;
  logic              busy;

  always #5 clk = ~clk;

  clk_div_ratio_ctrl #(.W(W), .NREQ(NREQ), .RESET_RATIO(RESET_RATIO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .req_ratio(req_ratio),
    .ack(ack), .err(err), .div_out(div_out), .tick(tick),
    .cur_ratio(cur_ratio), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int              m_cnt, m_R, m_pend, m_pr, m_pi, m_at, m_rr, cyc;
  logic [NREQ-1:0] m_ack, m_err;
  logic            m_div;

  // Samples of the DUT outputs from the last stepped cycle
  logic [NREQ-1:0] s_ack, s_err;
  logic            s_div, s_tick, s_busy;
  logic [W-1:0]    s_ratio;

  function automatic bit legal(input int r);
`ifdef CLKDIV_RATIO1_EN
    return r >= 1;
`else
    return r >= 2;
`endif
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_R    = RESET_RATIO;
    m_pend = 0;
    m_rr   = 0;
    m_ack  = '0;
    m_err  = '0;
    m_div  = 1'b0;
  endtask

  // One clock cycle: inputs already applied; compare at negedge, advance model
  // at posedge, return #1 after the edge ready for the next cycle's inputs.
  task automatic step();
    bit              e_tick;
    int              gi, r, idx, n_cnt;
    logic [NREQ-1:0] n_ack, n_err;
    bit              n_div;
    e_tick = enable && (m_cnt == m_R - 1);
    gi = -1;
    if (m_pend == 0 && m_ack == '0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (gi < 0 && req[idx]) gi = idx;
      end
    end
    @(negedge clk);
    s_ack = ack; s_err = err; s_div = div_out; s_tick = tick;
    s_ratio = cur_ratio; s_busy = busy;
    chk("model_ack", 32'(ack), 32'(m_ack));
    chk("model_err", 32'(err), 32'(m_err));
    chk("model_div_out", 32'(div_out), 32'(m_div));
    chk("model_tick", 32'(tick), 32'(e_tick));
    chk("model_cur_ratio", 32'(cur_ratio), 32'(m_R));
    chk("model_busy", 32'(busy), 32'(m_pend));
    @(posedge clk);
    n_ack = '0;
    n_err = '0;
    n_div = enable && (m_cnt < (m_R + 1) / 2);
    n_cnt = (enable && !e_tick) ? m_cnt + 1 : 0;
    if (gi >= 0) begin
      r    = int'(req_ratio[gi*W +: W]);
      m_rr = (gi + 1) % NREQ;
      if (!legal(r)) begin
        n_ack[gi] = 1'b1;
        n_err[gi] = 1'b1;
      end else if (!enable || e_tick) begin
        m_R       = r;
        n_ack[gi] = 1'b1;
      end else begin
        m_pend = 1;
        m_pr   = r;
        m_pi   = gi;
        m_at   = cyc + (m_R - 1 - m_cnt);
      end
    end else if (m_pend != 0 && (!enable || cyc == m_at)) begin
      m_R         = m_pr;
      n_ack[m_pi] = 1'b1;
      m_pend      = 0;
    end
    m_cnt = n_cnt;
    m_div = n_div;
    m_ack = n_ack;
    m_err = n_err;
    if (rst) model_reset();
    cyc++;
    #1;
  endtask

  task automatic run_until_ack(input int limit, input logic [NREQ-1:0] exp_ack,
                               input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (s_ack == '0 && n < limit);
    chk(nm, 32'(s_ack), 32'(exp_ack));
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic div;
    logic tk;
  } vec_t;

  vec_t tbl[12];
  logic [NREQ-1:0] drop;
  int              rr_sel;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, then enable at R=4: div_out 1100 repeating, tick every 4th cycle
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; enable = 1'b0; req = '0; req_ratio = '0; drop = '0;
    cyc = 0;
    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      rst    = tbl[i].rst;
      enable = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_div_out", i), 32'(s_div), 32'(tbl[i].div));
      chk($sformatf("tbl%0d_tick", i), 32'(s_tick), 32'(tbl[i].tk));
      chk($sformatf("tbl%0d_cur_ratio", i), 32'(s_ratio), 32'(RESET_RATIO));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'd0);
    end

    // R=4 -> 6, granted at cnt=1: old period completes, ack at first cnt=0
    enable = 1'b1;
    step();
    req[0] = 1'b1; req_ratio[0*W +: W] = 8'd6;
    step();
    chk("chg6_grant_busy", 32'(s_busy), 32'd0);
    step();
    chk("chg6_busy1", 32'(s_busy), 32'd1);
    chk("chg6_no_early_ack", 32'(s_ack), 32'd0);
    step();
    chk("chg6_busy2", 32'(s_busy), 32'd1);
    chk("chg6_boundary_tick", 32'(s_tick), 32'd1);
    chk("chg6_old_ratio", 32'(s_ratio), 32'd4);
    step();
    chk("chg6_ack", 32'(s_ack), 32'b01);
    chk("chg6_busy_clear", 32'(s_busy), 32'd0);
    chk("chg6_new_ratio", 32'(s_ratio), 32'd6);
    req[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("chg6_div_out_%0d", i), 32'(s_div), 32'(i < 3));
    end

    // simultaneous pair after index 0 was last served: index 1 goes first
    req = 2'b11; req_ratio[0*W +: W] = 8'd3; req_ratio[1*W +: W] = 8'd5;
    run_until_ack(12, 2'b10, "pair_rr_first_ack1");
    chk("pair_rr_ratio5", 32'(s_ratio), 32'd5);
    req[1] = 1'b0;
    step();
    chk("pair_rr_second_grant_busy", 32'(s_busy), 32'd0);
    run_until_ack(12, 2'b01, "pair_rr_then_ack0");
    chk("pair_rr_ratio3", 32'(s_ratio), 32'd3);
    req[0] = 1'b0;

    // illegal ratio 0: ack+err one cycle after grant, ratio unchanged
    req[1] = 1'b1; req_ratio[1*W +: W] = 8'd0;
    step();
    chk("rej0_grant_cycle_ack", 32'(s_ack), 32'd0);
    step();
    chk("rej0_ack", 32'(s_ack), 32'b10);
    chk("rej0_err", 32'(s_err), 32'b10);
    chk("rej0_ratio", 32'(s_ratio), 32'd3);
    req[1] = 1'b0;
    step();
    chk("rej0_ack_one_cycle", 32'(s_ack), 32'd0);
`ifndef CLKDIV_RATIO1_EN
    req[1] = 1'b1; req_ratio[1*W +: W] = 8'd1;
    step();
    step();
    chk("rej1_ack", 32'(s_ack), 32'b10);
    chk("rej1_err", 32'(s_err), 32'b10);
    chk("rej1_ratio", 32'(s_ratio), 32'd3);
    req[1] = 1'b0;
    step();
`endif

    // pending change to 8, enable dropped before the boundary
    begin
      int n;
      n = 0;
      do begin step(); n++; end while (!s_tick && n < 10);
      chk("pend8_found_tick", 32'(s_tick), 32'd1);
    end
    req[0] = 1'b1; req_ratio[0*W +: W] = 8'd8;
    step();
    enable = 1'b0;
    step();
    chk("pend8_busy", 32'(s_busy), 32'd1);
    step();
    chk("pend8_ack", 32'(s_ack), 32'b01);
    chk("pend8_ratio", 32'(s_ratio), 32'd8);
    chk("pend8_div_low", 32'(s_div), 32'd0);
    chk("pend8_busy_clear", 32'(s_busy), 32'd0);
    req[0] = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("r8_tick_%0d", i), 32'(s_tick), 32'(i == 7));
      chk($sformatf("r8_div_%0d", i), 32'(s_div), 32'(i >= 1 && i <= 4));
    end

    // reset while a change is pending: discarded, no ack
    req[0] = 1'b1; req_ratio[0*W +: W] = 8'd3;
    step();
    step();
    chk("rstpend_busy", 32'(s_busy), 32'd1);
    rst = 1'b1; enable = 1'b0; req[0] = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rstpend_ack", 32'(s_ack), 32'd0);
    chk("rstpend_err", 32'(s_err), 32'd0);
    chk("rstpend_ratio", 32'(s_ratio), 32'(RESET_RATIO));
    chk("rstpend_busy_clear", 32'(s_busy), 32'd0);
    chk("rstpend_div", 32'(s_div), 32'd0);
    chk("rstpend_tick", 32'(s_tick), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rstpend_no_ack_%0d", i), 32'(s_ack), 32'd0);
    end

    // fresh pointer after reset: index 0 first, index 1 next boundary
    enable = 1'b1;
    req = 2'b11; req_ratio[0*W +: W] = 8'd3; req_ratio[1*W +: W] = 8'd5;
    run_until_ack(12, 2'b01, "pair_reset_ack0");
    chk("pair_reset_ratio3", 32'(s_ratio), 32'd3);
    req[0] = 1'b0;
    run_until_ack(12, 2'b10, "pair_reset_ack1");
    chk("pair_reset_ratio5", 32'(s_ratio), 32'd5);
    req[1] = 1'b0;

    // randomized phase against the reference model
    drop = '0;
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) enable = !enable;
      for (int i = 0; i < NREQ; i++) begin
        if (drop[i]) begin
          req[i]  = 1'b0;
          drop[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          rr_sel = $urandom_range(0, 15);
          if (rr_sel > 12) rr_sel = $urandom_range(0, 1);
          req[i] = 1'b1;
          req_ratio[i*W +: W] = W'(rr_sel);
        end
      end
      step();
      for (int i = 0; i < NREQ; i++)
        if (s_ack[i]) drop[i] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
